frame_window_reader: RTL and testbench
======================================

// Module: frame_window_reader
// PURPOSE
//  Parametrised successor of the VGA-side address translator and pixel mapper. Runs in the VGA pixel clock domain.
//  Takes the raster h/v position and issues read addresses into the camera frame RAM, with an integer 1x/2x/4x upscale.
//  Places the image window at a runtime x/y offset and aligns the RAM read latency.
//  Maps each stored byte to RGB332 using one of four colour modes; pixels outside the window are driven black.
// PARAMETERS
//  H_ACTIVE   640    visible pixels per line
//  V_ACTIVE   480    visible lines per frame
//  V_TOTAL    525    total lines per frame, incl. blanking (v counts 0..V_TOTAL-1)
//  IMG_W      160    stored image width, pixels
//  IMG_H      120    stored image height, lines
//  ADDR_BITS  15     RAM address width; IMG_W*IMG_H <= 2**ADDR_BITS
//  RAM_LAT    1      RAM read latency, cycles, addr_r -> ram_data (>=1)
// PORTS
//  dclk       in   1          pixel clock
//  rst        in   1          synchronous reset, active-high
//  h          in   10         raster column from VGA timing
//  v          in   10         raster line from VGA timing
//  scale      in   2          0=1x 1=2x 2=4x 3=4x
//  x_off      in   10         window left column
//  y_off      in   10         window top line
//  mode       in   2          colour mode, see BEHAVIOUR
//  addr_r     out  ADDR_BITS  RAM read address
//  ram_data   in   8          RAM read data
//  red        out  3          pixel red
//  green      out  3          pixel green
//  blue       out  2          pixel blue
//  pix_valid  out  1          1 = current output pixel comes from the image
// BEHAVIOUR
//  Reset: addr_r=0, red/green/blue=0, pix_valid=0. Shadow config resets to scale=0, x_off=0, y_off=0, mode=0. All counters 0, in_x=in_y=0.
//  Config latch: scale/x_off/y_off/mode are copied to shadow registers only when v==V_ACTIVE && h==0.
//   - Changes mid-frame never tear the image; they take effect on the next frame. All logic below uses the shadow values.
//  Replication factor: S = 1<<scale_sh (1, 2, 4; scale_sh=3 is treated as 4).
//  Vertical tracking: updated once per line, at h==H_ACTIVE, and always refers to the next line.
//   - Next line: nv = (v==V_TOTAL-1) ? 0 : v+1.
//   - If nv==y_off: in_y=1, row=0, vrep=0, row_base=0.
//   - Else if in_y: vrep++. When vrep wraps at S-1, row++ and row_base += IMG_W.
//   - If row==IMG_H-1 at that wrap, in_y=0.
//   - No multiplier anywhere; row_base is accumulated.
//  Horizontal tracking, per cycle:
//   - If h==x_off && in_y && h<H_ACTIVE: in_x=1, col=0, hrep=0.
//   - Else if in_x: hrep++. When hrep wraps at S-1, col++.
//   - If col==IMG_W-1 at that wrap, in_x=0.
//   - h==H_ACTIVE forces in_x=0; a window extending past H_ACTIVE or V_ACTIVE is clipped.
//  Address: addr_r <= row_base + col, registered.
//   - addr_r holds its last value when not in the window; the output is masked regardless.
//  Latency: h/v sampled at cycle t -> addr_r valid at t+1 -> ram_data at t+1+RAM_LAT -> red/green/blue/pix_valid at t+2+RAM_LAT.
//   - The window flag (in_x & in_y) is delayed through a RAM_LAT+1 shift register to stay aligned with ram_data.
//   - The shadow mode is applied at the output stage.
//  Colour modes, d=ram_data:
//   - mode 0 (gray): r=d[7:5], g=d[7:5], b=d[7:6].
//   - mode 1 (RGB332 pass): r=d[7:5], g=d[4:2], b=d[1:0].
//   - mode 2 (inverted gray): as mode 0 applied to ~d.
//   - mode 3 (threshold): d>=8'h80 -> all ones, else 0.
//  Window flag 0 -> red=green=blue=0 and pix_valid=0.
//  Reset asserted mid-frame: all outputs are 0 the next cycle. The first image appears after a subsequent h==x_off with in_y=1.
//   - in_y can only set at h==H_ACTIVE, so a partial first line is never shown.
// TESTING
//  1. 1x, offsets 0, mode 1, RAM returns address LSBs.
//     -> line 0 pixels 0..159 give addr_r 0..159 at latency 2+RAM_LAT.
//     -> pixel 160 onward and line 120 onward are black, pix_valid=0.
//  2. scale=1, x_off=100, y_off=40.
//     -> addr_r holds each value 2 cycles; lines 40,41 read base 0; line 42 base 160.
//     -> h=99 is black, h=100 is valid, h=420 is black.
//  3. scale=2, x_off=0, y_off=0.
//     -> the image spans 640x480 exactly. Last pixel (639,479) reads addr 19199; in_x clears at h=640.
//  4. x_off=600, 1x.
//     -> only cols 0..39 are shown; h>=640 is black; the next line starts at col 0 with base advanced by 160.
//  5. Change scale from 0 to 1 at line 200.
//     -> the current frame stays 1x; 2x takes effect from v=0 of the next frame.
//  6. Modes 0/2/3 with d=8'hA5.
//     -> mode 0: r=5, g=5, b=2.
//     -> mode 2: r=2, g=2, b=1.
//     -> mode 3: r=7, g=7, b=3.
//     -> rst mid-line: outputs 0 the next cycle.

Source files
------------

// File: rtl/frame_window_reader.sv
// Raster-to-frame-RAM reader: windowed 1x/2x/4x upscale with RGB332 colour mapping.
// Address, RAM data and window flag are kept aligned through RAM_LAT.
module frame_window_reader #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int V_TOTAL   = 525,
   parameter int IMG_W     = 160,
   parameter int IMG_H     = 120,
   parameter int ADDR_BITS = 15,
   parameter int RAM_LAT   = 1
) (
   input  logic                 dclk,
   input  logic                 rst,
   input  logic [9:0]           h,
   input  logic [9:0]           v,
   input  logic [1:0]           scale,
   input  logic [9:0]           x_off,
   input  logic [9:0]           y_off,
   input  logic [1:0]           mode,
   output logic [ADDR_BITS-1:0] addr_r,
   input  logic [7:0]           ram_data,
   output logic [2:0]           red,
   output logic [2:0]           green,
   output logic [1:0]           blue,
   output logic                 pix_valid
);

   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = $clog2(IMG_H + 1);
   localparam logic [9:0] HA  = 10'(H_ACTIVE);
   localparam logic [9:0] VA  = 10'(V_ACTIVE);
   localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [ADDR_BITS-1:0] W_STEP = ADDR_BITS'(IMG_W);

   logic [1:0]           r_scale_sh;
   logic [9:0]           r_xoff_sh;
   logic [9:0]           r_yoff_sh;
   logic [1:0]           r_mode_sh;
   logic                 r_in_y;
   logic [1:0]           r_vrep;
   logic [RW-1:0]        r_row;
   logic [ADDR_BITS-1:0] r_row_base;
   logic                 r_in_x;
   logic [1:0]           r_hrep;
   logic [CW-1:0]        r_col;
   logic [RAM_LAT:0]     r_win_sr;

   logic [1:0]           w_smax;
   logic [9:0]           w_nv;
   logic                 w_inx_nx;
   logic [1:0]           w_hrep_nx;
   logic [CW-1:0]        w_col_nx;
   logic                 w_win;
   logic [ADDR_BITS-1:0] w_addr_nx;
   logic [7:0]           w_d;
   logic [7:0]           w_rgb;

   always_comb begin
      case (r_scale_sh)
         2'd0:    w_smax = 2'd0;
         2'd1:    w_smax = 2'd1;
         default: w_smax = 2'd3;
      endcase
   end

   assign w_nv = (v == VT1) ? 10'd0 : v + 10'd1;

   // Next horizontal state describes the pixel at the current h,
   // so the address can be registered one cycle after h.
   always_comb begin
      w_inx_nx  = 1'b0;
      w_col_nx  = r_col;
      w_hrep_nx = r_hrep;
      if (h == HA) begin
         w_inx_nx = 1'b0;
      end else if (h == r_xoff_sh && r_in_y && h < HA) begin
         w_inx_nx  = 1'b1;
         w_col_nx  = '0;
         w_hrep_nx = 2'd0;
      end else if (r_in_x) begin
         if (r_hrep == w_smax) begin
            w_hrep_nx = 2'd0;
            w_col_nx  = r_col + 1'b1;
            w_inx_nx  = (r_col != COL_LAST);
         end else begin
            w_hrep_nx = r_hrep + 2'd1;
            w_inx_nx  = 1'b1;
         end
      end
   end

   assign w_win     = w_inx_nx & r_in_y;
   assign w_addr_nx = r_row_base + ADDR_BITS'(w_col_nx);

   assign w_d = (r_mode_sh == 2'd2) ? ~ram_data : ram_data;

   always_comb begin
      case (r_mode_sh)
         2'd1:    w_rgb = w_d;
         2'd3:    w_rgb = w_d[7] ? 8'hFF : 8'h00;
         default: w_rgb = {w_d[7:5], w_d[7:5], w_d[7:6]};
      endcase
   end

   always_ff @(posedge dclk) begin
      if (rst) begin
         r_scale_sh <= 2'd0;
         r_xoff_sh  <= 10'd0;
         r_yoff_sh  <= 10'd0;
         r_mode_sh  <= 2'd0;
         r_in_y     <= 1'b0;
         r_vrep     <= 2'd0;
         r_row      <= '0;
         r_row_base <= '0;
         r_in_x     <= 1'b0;
         r_hrep     <= 2'd0;
         r_col      <= '0;
         r_win_sr   <= '0;
         addr_r     <= '0;
         red        <= 3'd0;
         green      <= 3'd0;
         blue       <= 2'd0;
         pix_valid  <= 1'b0;
      end else begin
         if (v == VA && h == 10'd0) begin
            r_scale_sh <= scale;
            r_xoff_sh  <= x_off;
            r_yoff_sh  <= y_off;
            r_mode_sh  <= mode;
         end
         r_in_x <= w_inx_nx;
         r_col  <= w_col_nx;
         r_hrep <= w_hrep_nx;
         if (w_win)
            addr_r <= w_addr_nx;
         // Vertical state is prepared for the line that follows.
         if (h == HA) begin
            if (w_nv >= VA) begin
               r_in_y <= 1'b0;
            end else if (w_nv == r_yoff_sh) begin
               r_in_y     <= 1'b1;
               r_row      <= '0;
               r_vrep     <= 2'd0;
               r_row_base <= '0;
            end else if (r_in_y) begin
               if (r_vrep == w_smax) begin
                  r_vrep     <= 2'd0;
                  r_row      <= r_row + 1'b1;
                  r_row_base <= r_row_base + W_STEP;
                  if (r_row == ROW_LAST)
                     r_in_y <= 1'b0;
               end else begin
                  r_vrep <= r_vrep + 2'd1;
               end
            end
         end
         r_win_sr <= {r_win_sr[RAM_LAT-1:0], w_win};
         if (r_win_sr[RAM_LAT]) begin
            red       <= w_rgb[7:5];
            green     <= w_rgb[4:2];
            blue      <= w_rgb[1:0];
            pix_valid <= 1'b1;
         end else begin
            red       <= 3'd0;
            green     <= 3'd0;
            blue      <= 2'd0;
            pix_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_window_reader.sv
// Bench for frame_window_reader: directed raster lines against a
// one-cycle RAM model, captured per column and compared with a vector table.
module tb_frame_window_reader;

   logic        dclk = 1'b0;
   logic        rst;
   logic [9:0]  h, v;
   logic [1:0]  scale;
   logic [9:0]  x_off, y_off;
   logic [1:0]  mode;
   logic [14:0] addr_r;
   logic [7:0]  ram_data;
   logic [2:0]  red, green;
   logic [1:0]  blue;
   logic        pix_valid;
   logic        ram_force;

   int checks = 0;
   int failures = 0;

   frame_window_reader dut (
      .dclk(dclk), .rst(rst), .h(h), .v(v), .scale(scale),
      .x_off(x_off), .y_off(y_off), .mode(mode), .addr_r(addr_r),
      .ram_data(ram_data), .red(red), .green(green), .blue(blue),
      .pix_valid(pix_valid)
   );

   always #5 dclk = ~dclk;

   // RAM model, latency 1: returns address LSBs or a fixed byte
   always_ff @(posedge dclk)
      ram_data <= ram_force ? 8'hA5 : addr_r[7:0];

   typedef struct {
      int tag;
      int hh;
      int val;
      int addr;
      int rgb;
   } vec_t;

   vec_t tbl[$];

   int cap_addr[0:1023];
   int cap_val[0:1023];
   int cap_rgb[0:1023];
   int p1_h, p2_h, p3_h;
   bit p1_r, p2_r, p3_r;

   function automatic void add(int tag, int hh, int val, int addr, int rgb);
      vec_t e;
      e.tag = tag; e.hh = hh; e.val = val; e.addr = addr; e.rgb = rgb;
      tbl.push_back(e);
   endfunction

   task automatic chk(input string nm, input int tag, input int hh,
                      input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s tag=%0d h=%0d got=%0d expected=%0d",
                  nm, tag, hh, act, exp);
      end
   endtask

   task automatic tick(input int hh, input int vv, input bit rec);
      @(negedge dclk);
      if (p1_r) cap_addr[p1_h] = int'(addr_r);
      if (p3_r) begin
         cap_val[p3_h] = int'(pix_valid);
         cap_rgb[p3_h] = int'({red, green, blue});
      end
      p3_h = p2_h; p3_r = p2_r;
      p2_h = p1_h; p2_r = p1_r;
      p1_h = hh;   p1_r = rec;
      h = 10'(hh);
      v = 10'(vv);
   endtask

   task automatic check_tag(input int tag);
      foreach (tbl[i]) begin
         if (tbl[i].tag == tag) begin
            if (tbl[i].val != 0) begin
               chk("valid", tag, tbl[i].hh, cap_val[tbl[i].hh], 1);
               if (tbl[i].addr >= 0)
                  chk("addr", tag, tbl[i].hh, cap_addr[tbl[i].hh], tbl[i].addr);
               chk("rgb", tag, tbl[i].hh, cap_rgb[tbl[i].hh], tbl[i].rgb);
            end else begin
               chk("valid", tag, tbl[i].hh, cap_val[tbl[i].hh], 0);
               chk("black", tag, tbl[i].hh, cap_rgb[tbl[i].hh], 0);
            end
         end
      end
   endtask

   task automatic run_line(input int vv, input int tag);
      for (int hh = 0; hh <= 640; hh++) tick(hh, vv, 1'b1);
      for (int k = 0; k < 3; k++) tick(700, vv, 1'b0);
      if (tag > 0) check_tag(tag);
   endtask

   task automatic fast_lines(input int v0, input int v1);
      for (int vv = v0; vv <= v1; vv++) tick(640, vv, 1'b0);
   endtask

   task automatic setup(input int sc, input int xo, input int yo, input int md);
      scale = 2'(sc); x_off = 10'(xo); y_off = 10'(yo); mode = 2'(md);
      tick(0, 480, 1'b0);
      tick(700, 480, 1'b0);
   endtask

   task automatic fstart();
      tick(640, 524, 1'b0);
   endtask

   initial begin
      // Hand-computed vectors: {tag, h, valid, addr (-1 = skip), rgb}
      add(1, 0, 1, 0, 0);         add(1, 1, 1, 1, 1);
      add(1, 100, 1, 100, 100);   add(1, 159, 1, 159, 159);
      add(1, 160, 0, 0, 0);       add(1, 300, 0, 0, 0);
      add(1, 639, 0, 0, 0);
      add(2, 0, 1, 19040, 96);    add(2, 159, 1, 19199, 255);
      add(3, 0, 0, 0, 0);         add(3, 80, 0, 0, 0);
      add(4, 99, 0, 0, 0);        add(4, 100, 1, 0, 0);
      add(4, 101, 1, 0, 0);       add(4, 102, 1, 1, 1);
      add(4, 103, 1, 1, 1);       add(4, 419, 1, 159, 159);
      add(4, 420, 0, 0, 0);
      add(5, 100, 1, 0, 0);       add(5, 101, 1, 0, 0);
      add(6, 100, 1, 160, 160);   add(6, 102, 1, 161, 161);
      add(7, 0, 1, 0, 0);         add(7, 3, 1, 0, 0);
      add(7, 4, 1, 1, 1);         add(7, 639, 1, 159, 159);
      add(7, 640, 0, 0, 0);
      add(8, 0, 1, 19040, 96);    add(8, 639, 1, 19199, 255);
      add(9, 599, 0, 0, 0);       add(9, 600, 1, 0, 0);
      add(9, 639, 1, 39, 39);     add(9, 640, 0, 0, 0);
      add(10, 599, 0, 0, 0);      add(10, 600, 1, 160, 160);
      add(10, 639, 1, 199, 199);
      add(11, 1, 1, 161, 161);    add(11, 2, 1, 162, 162);
      add(12, 1, 1, 0, 0);        add(12, 2, 1, 1, 1);
      add(12, 3, 1, 1, 1);
      add(13, 0, 1, 0, 0);        add(13, 2, 1, 1, 1);
      add(14, 5, 1, -1, 8'hB6);   add(14, 200, 0, 0, 0);
      add(15, 5, 1, -1, 8'h49);
      add(16, 5, 1, -1, 8'hFF);   add(16, 200, 0, 0, 0);
      add(17, 5, 1, -1, 8'hB6);
      add(18, 5, 0, 0, 0);

      foreach (cap_val[i]) begin
         cap_val[i] = 0; cap_addr[i] = 0; cap_rgb[i] = 0;
      end
      p1_h = 0; p2_h = 0; p3_h = 0;
      p1_r = 0; p2_r = 0; p3_r = 0;
      rst = 1'b1; ram_force = 1'b0;
      h = 10'd700; v = 10'd0;
      scale = 2'd0; x_off = 10'd0; y_off = 10'd0; mode = 2'd0;
      repeat (3) @(negedge dclk);
      chk("rst_addr", 0, 0, int'(addr_r), 0);
      chk("rst_valid", 0, 0, int'(pix_valid), 0);
      chk("rst_rgb", 0, 0, int'({red, green, blue}), 0);
      rst = 1'b0;

      // 1x at origin, RGB332 pass-through
      setup(0, 0, 0, 1);
      fstart();
      run_line(0, 1);
      fast_lines(1, 118);
      run_line(119, 2);
      run_line(120, 3);

      // 2x at (100,40)
      setup(1, 100, 40, 1);
      fstart();
      fast_lines(0, 39);
      run_line(40, 4);
      run_line(41, 5);
      run_line(42, 6);

      // 4x fills the whole screen
      setup(2, 0, 0, 1);
      fstart();
      run_line(0, 7);
      fast_lines(1, 478);
      run_line(479, 8);

      // Window clipped at the right edge
      setup(0, 600, 0, 1);
      fstart();
      run_line(0, 9);
      run_line(1, 10);

      // Mid-frame scale change waits for the next frame
      setup(0, 0, 0, 1);
      fstart();
      run_line(0, 0);
      scale = 2'd1;
      run_line(1, 11);
      setup(1, 0, 0, 1);
      fstart();
      run_line(0, 12);
      run_line(1, 13);

      // Colour modes with a fixed byte
      ram_force = 1'b1;
      setup(0, 0, 0, 0);
      fstart();
      run_line(0, 14);
      setup(0, 0, 0, 2);
      fstart();
      run_line(0, 15);
      setup(0, 0, 0, 3);
      fstart();
      run_line(0, 16);

      // Reset in the middle of a visible line
      fstart();
      for (int hh = 0; hh <= 10; hh++) tick(hh, 0, 1'b0);
      chk("pre_rst_valid", 19, 7, int'(pix_valid), 1);
      chk("pre_rst_rgb", 19, 7, int'({red, green, blue}), 8'hFF);
      rst = 1'b1;
      @(negedge dclk);
      chk("midrst_valid", 19, 10, int'(pix_valid), 0);
      chk("midrst_rgb", 19, 10, int'({red, green, blue}), 0);
      chk("midrst_addr", 19, 10, int'(addr_r), 0);
      rst = 1'b0;
      run_line(1, 18);
      fstart();
      run_line(0, 17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
